// File: rtl/el2_pkg.sv
// Core configuration types and DCCM arbitration constants shared by the LSU DCCM arbiter.
package el2_pkg;

  typedef struct packed {
    logic [7:0] DCCM_BITS;
    logic [7:0] DCCM_FDATA_WIDTH;
  } el2_param_t;

  localparam el2_param_t EL2_PARAM_DEFAULT = '{DCCM_BITS: 8'd16, DCCM_FDATA_WIDTH: 8'd39};

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_SB   = 2'd3
  } el2_dccm_owner_e;

  localparam int EL2_DCCM_STARVE_W = 4;

  function automatic logic el2_starve_boost(input logic [EL2_DCCM_STARVE_W-1:0] cnt,
                                            input logic [EL2_DCCM_STARVE_W-1:0] max);
    return cnt >= max;
  endfunction

endpackage

// File: rtl/el2_lsu_dccm_arb_if.sv
// Requester, DCCM and read-return signals of the DCCM arbiter; slave = arbiter side.
interface el2_lsu_dccm_arb_if #(
  parameter int AW = 16,
  parameter int DW = 39
);
  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr_lo;
  logic [AW-1:0] lsu_addr_hi;

  logic          dma_req_valid;
  logic          dma_req_ready;
  logic          dma_req_write;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;

  logic          sb_req_valid;
  logic          sb_req_ready;
  logic [AW-1:0] sb_addr_lo;
  logic [AW-1:0] sb_addr_hi;
  logic [DW-1:0] sb_wdata_lo;
  logic [DW-1:0] sb_wdata_hi;

  logic          dccm_wren;
  logic          dccm_rden;
  logic [AW-1:0] dccm_wr_addr_lo;
  logic [AW-1:0] dccm_wr_addr_hi;
  logic [AW-1:0] dccm_rd_addr_lo;
  logic [AW-1:0] dccm_rd_addr_hi;
  logic [DW-1:0] dccm_wr_data_lo;
  logic [DW-1:0] dccm_wr_data_hi;
  logic [DW-1:0] dccm_rd_data_lo;
  logic [DW-1:0] dccm_rd_data_hi;

  logic          lsu_rd_valid;
  logic          dma_rd_valid;
  logic [DW-1:0] rd_data_lo;
  logic [DW-1:0] rd_data_hi;
  logic          arb_boost;

  modport slave (
    input  lsu_req_valid, lsu_addr_lo, lsu_addr_hi,
    input  dma_req_valid, dma_req_write, dma_addr, dma_wdata,
    input  sb_req_valid, sb_addr_lo, sb_addr_hi, sb_wdata_lo, sb_wdata_hi,
    input  dccm_rd_data_lo, dccm_rd_data_hi,
    output lsu_req_ready, dma_req_ready, sb_req_ready,
    output dccm_wren, dccm_rden,
    output dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi,
    output dccm_wr_data_lo, dccm_wr_data_hi,
    output lsu_rd_valid, dma_rd_valid, rd_data_lo, rd_data_hi, arb_boost
  );

  modport master (
    output lsu_req_valid, lsu_addr_lo, lsu_addr_hi,
    output dma_req_valid, dma_req_write, dma_addr, dma_wdata,
    output sb_req_valid, sb_addr_lo, sb_addr_hi, sb_wdata_lo, sb_wdata_hi,
    output dccm_rd_data_lo, dccm_rd_data_hi,
    input  lsu_req_ready, dma_req_ready, sb_req_ready,
    input  dccm_wren, dccm_rden,
    input  dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi,
    input  dccm_wr_data_lo, dccm_wr_data_hi,
    input  lsu_rd_valid, dma_rd_valid, rd_data_lo, rd_data_hi, arb_boost
  );

endinterface

// File: rtl/el2_dccm_starve_cnt.sv
// Saturating wait counter for one requester; boost once it has waited max_i cycles.
module el2_dccm_starve_cnt
  import el2_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         valid_i,
  input  logic                         grant_i,
  input  logic [EL2_DCCM_STARVE_W-1:0] max_i,
  output logic                         boost_o
);

  logic [EL2_DCCM_STARVE_W-1:0] cnt_d;
  logic [EL2_DCCM_STARVE_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!valid_i || grant_i) cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
  end

  rvdff #(.WIDTH(EL2_DCCM_STARVE_W)) u_cnt_ff (
    .clk  (clk),
    .rst_l(rst_l),
    .din  (cnt_d),
    .dout (cnt_q)
  );

  assign boost_o = valid_i && el2_starve_boost(cnt_q, max_i);

endmodule

// File: rtl/el2_rvdff.sv
// Plain D flop vector with asynchronous active-low reset to zero.
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= '0;
    else        dout <= din;
  end

endmodule

// File: rtl/el2_lsu_dccm_arb.sv
// Single-port DCCM arbiter between LSU loads, DMA and store-buffer drain, with read return routing.
module el2_lsu_dccm_arb
  import el2_pkg::*;
#(
  parameter el2_param_t pt             = EL2_PARAM_DEFAULT,
  parameter int         DMA_STARVE_MAX = 4,
  parameter int         SB_STARVE_MAX  = 8
) (
  input logic               clk,
  input logic               rst_l,
  el2_lsu_dccm_arb_if.slave bus
);

  localparam int AW = int'(pt.DCCM_BITS);
  localparam int DW = int'(pt.DCCM_FDATA_WIDTH);
  localparam logic [EL2_DCCM_STARVE_W-1:0] DMA_MAX = EL2_DCCM_STARVE_W'(DMA_STARVE_MAX);
  localparam logic [EL2_DCCM_STARVE_W-1:0] SB_MAX  = EL2_DCCM_STARVE_W'(SB_STARVE_MAX);

  el2_dccm_owner_e sel;
  logic            dma_boost, sb_boost;
  logic            dma_boost_act, sb_boost_act;
  logic            boost_hold_d, boost_hold_q;
  logic            own_lsu_d, own_lsu_q;
  logic            own_dma_d, own_dma_q;
  logic            lsu_gnt, dma_gnt, sb_gnt;
  logic            wren, rden;
  logic [AW-1:0]   addr_lo, addr_hi;
  logic [DW-1:0]   wdata_lo, wdata_hi;

  el2_dccm_starve_cnt u_dma_starve (
    .clk    (clk),
    .rst_l  (rst_l),
    .valid_i(bus.dma_req_valid),
    .grant_i(dma_gnt),
    .max_i  (DMA_MAX),
    .boost_o(dma_boost)
  );

  el2_dccm_starve_cnt u_sb_starve (
    .clk    (clk),
    .rst_l  (rst_l),
    .valid_i(bus.sb_req_valid),
    .grant_i(sb_gnt),
    .max_i  (SB_MAX),
    .boost_o(sb_boost)
  );

  // The slot right after a boosted grant goes to a waiting LSU load, so two boosted
  // requesters cannot alternate and lock loads out indefinitely.
  always_comb begin
    dma_boost_act = dma_boost && !(boost_hold_q && bus.lsu_req_valid);
    sb_boost_act  = sb_boost  && !(boost_hold_q && bus.lsu_req_valid);
    sel           = OWN_NONE;
    if      (dma_boost_act)     sel = OWN_DMA;
    else if (sb_boost_act)      sel = OWN_SB;
    else if (bus.lsu_req_valid) sel = OWN_LSU;
    else if (bus.dma_req_valid) sel = OWN_DMA;
    else if (bus.sb_req_valid)  sel = OWN_SB;
  end

  always_comb begin
    lsu_gnt      = (sel == OWN_LSU);
    dma_gnt      = (sel == OWN_DMA);
    sb_gnt       = (sel == OWN_SB);
    rden         = lsu_gnt || (dma_gnt && !bus.dma_req_write);
    wren         = sb_gnt  || (dma_gnt &&  bus.dma_req_write);
    boost_hold_d = dma_boost_act || sb_boost_act;
    own_lsu_d    = lsu_gnt;
    own_dma_d    = dma_gnt && !bus.dma_req_write;
  end

  always_comb begin
    addr_lo  = '0;
    addr_hi  = '0;
    wdata_lo = '0;
    wdata_hi = '0;
    unique case (sel)
      OWN_LSU: begin
        addr_lo = bus.lsu_addr_lo;
        addr_hi = bus.lsu_addr_hi;
      end
      OWN_DMA: begin
        addr_lo  = bus.dma_addr;
        addr_hi  = bus.dma_addr;
        wdata_lo = bus.dma_wdata;
        wdata_hi = bus.dma_wdata;
      end
      OWN_SB: begin
        addr_lo  = bus.sb_addr_lo;
        addr_hi  = bus.sb_addr_hi;
        wdata_lo = bus.sb_wdata_lo;
        wdata_hi = bus.sb_wdata_hi;
      end
      default: ;
    endcase
  end

  rvdff #(.WIDTH(1)) u_boost_hold_ff (
    .clk(clk), .rst_l(rst_l), .din(boost_hold_d), .dout(boost_hold_q)
  );

  rvdff #(.WIDTH(1)) u_own_lsu_ff (
    .clk(clk), .rst_l(rst_l), .din(own_lsu_d), .dout(own_lsu_q)
  );

  rvdff #(.WIDTH(1)) u_own_dma_ff (
    .clk(clk), .rst_l(rst_l), .din(own_dma_d), .dout(own_dma_q)
  );

  assign bus.lsu_req_ready   = lsu_gnt;
  assign bus.dma_req_ready   = dma_gnt;
  assign bus.sb_req_ready    = sb_gnt;
  assign bus.dccm_wren       = wren;
  assign bus.dccm_rden       = rden;
  assign bus.dccm_wr_addr_lo = addr_lo;
  assign bus.dccm_wr_addr_hi = addr_hi;
  assign bus.dccm_rd_addr_lo = addr_lo;
  assign bus.dccm_rd_addr_hi = addr_hi;
  assign bus.dccm_wr_data_lo = wdata_lo;
  assign bus.dccm_wr_data_hi = wdata_hi;
  assign bus.arb_boost       = dma_boost_act || sb_boost_act;

  // Return data is only forwarded while an owner flop claims it; anything else,
  // including data from an access cut off by reset, is dropped.
  assign bus.lsu_rd_valid = own_lsu_q;
  assign bus.dma_rd_valid = own_dma_q;
  assign bus.rd_data_lo   = (own_lsu_q || own_dma_q) ? bus.dccm_rd_data_lo : '0;
  assign bus.rd_data_hi   = (own_lsu_q || own_dma_q) ? bus.dccm_rd_data_hi : '0;

endmodule

// File: tb/tb_el2_lsu_dccm_arb.sv
// Directed bench for the DCCM arbiter: priority, starvation boost, strobes and read return.
module tb_el2_lsu_dccm_arb;
  import el2_pkg::*;

  localparam el2_param_t PT = EL2_PARAM_DEFAULT;
  localparam int AW = 16;
  localparam int DW = 39;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  el2_lsu_dccm_arb_if #(.AW(AW), .DW(DW)) bus ();

  el2_lsu_dccm_arb #(
    .pt(PT), .DMA_STARVE_MAX(4), .SB_STARVE_MAX(8)
  ) u_dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.lsu_req_valid   = 1'b0;
    bus.lsu_addr_lo     = '0;
    bus.lsu_addr_hi     = '0;
    bus.dma_req_valid   = 1'b0;
    bus.dma_req_write   = 1'b0;
    bus.dma_addr        = '0;
    bus.dma_wdata       = '0;
    bus.sb_req_valid    = 1'b0;
    bus.sb_addr_lo      = '0;
    bus.sb_addr_hi      = '0;
    bus.sb_wdata_lo     = '0;
    bus.sb_wdata_hi     = '0;
    bus.dccm_rd_data_lo = '0;
    bus.dccm_rd_data_hi = '0;
  endtask

  function automatic logic [3:0] grants();
    return {bus.lsu_req_ready, bus.dma_req_ready, bus.sb_req_ready, bus.arb_boost};
  endfunction

  initial begin
    logic dma_pend;
    logic sb_pend;
    logic [3:0] exp_g;

    // Reset state
    idle();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'({bus.lsu_req_ready, bus.dma_req_ready, bus.sb_req_ready}), 64'h0);
    chk("rst_strobes", 64'({bus.dccm_wren, bus.dccm_rden, bus.arb_boost}), 64'h0);
    chk("rst_rd_valid", 64'({bus.lsu_rd_valid, bus.dma_rd_valid}), 64'h0);
    chk("rst_addr", 64'({bus.dccm_wr_addr_lo, bus.dccm_rd_addr_hi}), 64'h0);
    chk("rst_wdata", 64'(bus.dccm_wr_data_lo), 64'h0);
    chk("rst_cnt", 64'({u_dut.u_dma_starve.cnt_q, u_dut.u_sb_starve.cnt_q}), 64'h0);
    @(negedge clk);
    rst_l = 1'b1;

    // All three valid, no boost: LSU wins, read returns next cycle
    @(negedge clk);
    bus.lsu_req_valid = 1'b1; bus.lsu_addr_lo = 16'h0010; bus.lsu_addr_hi = 16'h0010;
    bus.dma_req_valid = 1'b1; bus.dma_addr = 16'h0020;
    bus.sb_req_valid  = 1'b1; bus.sb_addr_lo = 16'h0030; bus.sb_addr_hi = 16'h0030;
    #1;
    chk("t1_grants", 64'(grants()), 64'h8);
    chk("t1_strobes", 64'({bus.dccm_rden, bus.dccm_wren}), 64'h2);
    chk("t1_rd_addr", 64'({bus.dccm_rd_addr_hi, bus.dccm_rd_addr_lo}), 64'h0010_0010);
    @(posedge clk);
    #1;
    idle();
    bus.dccm_rd_data_lo = 39'h12_3456_789A;
    bus.dccm_rd_data_hi = 39'h2A_5555_AAAA;
    #1;
    chk("t1_lsu_rd_valid", 64'({bus.lsu_rd_valid, bus.dma_rd_valid}), 64'h2);
    chk("t1_rd_data_lo", 64'(bus.rd_data_lo), 64'h12_3456_789A);
    chk("t1_rd_data_hi", 64'(bus.rd_data_hi), 64'h2A_5555_AAAA);
    @(posedge clk);
    #1;
    chk("t1_rd_valid_drop", 64'({bus.lsu_rd_valid, bus.dma_rd_valid}), 64'h0);
    bus.dccm_rd_data_lo = '0;
    bus.dccm_rd_data_hi = '0;

    // LSU every cycle with a DMA read pending: DMA boosted on cycle 5
    dma_pend = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr_lo   = 16'(16'h0100 + c);
      bus.lsu_addr_hi   = 16'(16'h0100 + c);
      bus.dma_req_valid = dma_pend;
      bus.dma_req_write = 1'b0;
      bus.dma_addr      = 16'h0200;
      #1;
      exp_g = (c == 5) ? 4'b0101 : 4'b1000;
      chk($sformatf("t2_grants_c%0d", c), 64'(grants()), 64'(exp_g));
      chk($sformatf("t2_rden_c%0d", c), 64'(bus.dccm_rden), 64'h1);
      if (bus.dma_req_ready) dma_pend = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("t2_rd_valid_c%0d", c), 64'({bus.lsu_rd_valid, bus.dma_rd_valid}),
          (c == 5) ? 64'h1 : 64'h2);
    end
    idle();
    repeat (2) @(posedge clk);

    // SB waits from cycle 1, DMA from cycle 5: both boosted at cycle 9
    dma_pend = 1'b0;
    sb_pend  = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 5) dma_pend = 1'b1;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr_lo   = 16'h0300;
      bus.lsu_addr_hi   = 16'h0300;
      bus.dma_req_valid = dma_pend;
      bus.dma_addr      = 16'h0400;
      bus.sb_req_valid  = sb_pend;
      bus.sb_addr_lo    = 16'h0500;
      bus.sb_addr_hi    = 16'h0500;
      bus.sb_wdata_lo   = 39'h00_0000_5B5B;
      bus.sb_wdata_hi   = 39'h00_0000_5B5B;
      #1;
      exp_g = (c == 9) ? 4'b0101 : (c == 11) ? 4'b0011 : 4'b1000;
      chk($sformatf("t3_grants_c%0d", c), 64'(grants()), 64'(exp_g));
      if (bus.dma_req_ready) dma_pend = 1'b0;
      if (bus.sb_req_ready)  sb_pend  = 1'b0;
    end
    @(posedge clk);
    #1;
    idle();
    repeat (2) @(posedge clk);

    // DMA write alone
    @(negedge clk);
    bus.dma_req_valid = 1'b1;
    bus.dma_req_write = 1'b1;
    bus.dma_addr      = 16'h0040;
    bus.dma_wdata     = 39'h00_DEAD_BEEF;
    #1;
    chk("t4_grants", 64'(grants()), 64'h4);
    chk("t4_strobes", 64'({bus.dccm_wren, bus.dccm_rden}), 64'h2);
    chk("t4_wr_addr", 64'({bus.dccm_wr_addr_hi, bus.dccm_wr_addr_lo}), 64'h0040_0040);
    chk("t4_wr_data_lo", 64'(bus.dccm_wr_data_lo), 64'h00_DEAD_BEEF);
    chk("t4_wr_data_hi", 64'(bus.dccm_wr_data_hi), 64'h00_DEAD_BEEF);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("t4_dma_rd_valid", 64'(bus.dma_rd_valid), 64'h0);

    // Misaligned store-buffer write
    @(negedge clk);
    bus.sb_req_valid = 1'b1;
    bus.sb_addr_lo   = 16'h001C;
    bus.sb_addr_hi   = 16'h0020;
    bus.sb_wdata_lo  = 39'h0A_CAFE_F00D;
    bus.sb_wdata_hi  = 39'h05_1234_5678;
    #1;
    chk("t5_grants", 64'(grants()), 64'h2);
    chk("t5_strobes", 64'({bus.dccm_wren, bus.dccm_rden}), 64'h2);
    chk("t5_wr_addr", 64'({bus.dccm_wr_addr_hi, bus.dccm_wr_addr_lo}), 64'h0020_001C);
    chk("t5_wr_data_lo", 64'(bus.dccm_wr_data_lo), 64'h0A_CAFE_F00D);
    chk("t5_wr_data_hi", 64'(bus.dccm_wr_data_hi), 64'h05_1234_5678);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("t5_wren_one_cycle", 64'(bus.dccm_wren), 64'h0);

    // Reset one cycle after an LSU read grant, with DMA waiting
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr_lo   = 16'h0600;
    bus.lsu_addr_hi   = 16'h0600;
    bus.dma_req_valid = 1'b1;
    bus.dma_addr      = 16'h0700;
    #1;
    chk("t6_lsu_grant", 64'(grants()), 64'h8);
    @(posedge clk);
    #1;
    chk("t6_pre_rst_rd_valid", 64'(bus.lsu_rd_valid), 64'h1);
    chk("t6_pre_rst_cnt", 64'(u_dut.u_dma_starve.cnt_q), 64'h1);
    idle();
    rst_l = 1'b0;
    #1;
    chk("t6_rst_rd_valid", 64'({bus.lsu_rd_valid, bus.dma_rd_valid}), 64'h0);
    chk("t6_rst_cnt", 64'({u_dut.u_dma_starve.cnt_q, u_dut.u_sb_starve.cnt_q}), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    bus.dma_req_valid = 1'b1;
    bus.dma_req_write = 1'b0;
    bus.dma_addr      = 16'h0080;
    #1;
    chk("t6_post_grant", 64'(grants()), 64'h4);
    chk("t6_post_rd_addr", 64'({bus.dccm_rden, bus.dccm_rd_addr_lo}), 64'h1_0080);
    @(posedge clk);
    #1;
    idle();
    bus.dccm_rd_data_lo = 39'h00_0BAD_F00D;
    #1;
    chk("t6_post_dma_rd_valid", 64'({bus.lsu_rd_valid, bus.dma_rd_valid}), 64'h1);
    chk("t6_post_rd_data", 64'(bus.rd_data_lo), 64'h00_0BAD_F00D);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
